// File: rtl/vga_sprite_engine.sv
// VGA timing generator with an N-sprite rectangle compositor over a background colour.
// Optional per-sprite collision flags are enabled by defining SPRITE_COLLIDE_EN.
module vga_sprite_engine #(
  parameter int NUM_SPRITES = 3,
  parameter int COORD_W     = 16,
  parameter int COLOR_W     = 8,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SPRITES*COORD_W-1:0]     sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]     sprite_y,
  input  logic [NUM_SPRITES*3*COLOR_W-1:0]   sprite_color,
  input  logic [NUM_SPRITES-1:0]             sprite_en,
  input  logic [3*COLOR_W-1:0]               bg_color,
  output logic                               clk_25MHz,
  output logic                               h_sync,
  output logic                               v_sync,
  output logic                               sync_n,
  output logic                               blank_n,
  output logic [COLOR_W-1:0]                 red_out,
  output logic [COLOR_W-1:0]                 green_out,
  output logic [COLOR_W-1:0]                 blue_out,
`ifdef SPRITE_COLLIDE_EN
  output logic [NUM_SPRITES-1:0]             collide,
`endif
  output logic                               frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCNT_W   = $clog2(H_TOTAL);
  localparam int VCNT_W   = $clog2(V_TOTAL);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PIX_W    = 3 * COLOR_W;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [DIV_W-1:0]  div_cnt;
  logic              pix_tick;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              active;
  logic              latch;

  logic [NUM_SPRITES*COORD_W-1:0]   sh_x;
  logic [NUM_SPRITES*COORD_W-1:0]   sh_y;
  logic [NUM_SPRITES*PIX_W-1:0]     sh_col;
  logic [NUM_SPRITES-1:0]           sh_en;
  logic [PIX_W-1:0]                 sh_bg;

  logic [COORD_W:0]       h_pos;
  logic [COORD_W:0]       v_pos;
  logic [COORD_W:0]       x0;
  logic [COORD_W:0]       y0;
  logic [NUM_SPRITES-1:0] hit;
  logic [PIX_W-1:0]       pix_color;

  assign pix_tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign clk_25MHz = (32'(div_cnt) < 32'(CLK_DIV / 2));
  assign sync_n    = 1'b0;
  assign active    = (32'(hcnt) < 32'(H_ACTIVE)) && (32'(vcnt) < 32'(V_ACTIVE));
  assign latch     = pix_tick && (hcnt == '0) && (32'(vcnt) == 32'(V_ACTIVE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (32'(hcnt) == 32'(H_TOTAL - 1)) begin
        hcnt <= '0;
        if (32'(vcnt) == 32'(V_TOTAL - 1)) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + 1'b1;
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Shadows are taken at the top of vertical blanking so a frame never mixes old and new sprite state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_col <= '0;
      sh_en  <= '0;
      sh_bg  <= '0;
    end else if (latch) begin
      sh_x   <= sprite_x;
      sh_y   <= sprite_y;
      sh_col <= sprite_color;
      sh_en  <= sprite_en;
      sh_bg  <= bg_color;
    end
  end

  assign h_pos = (COORD_W+1)'(hcnt);
  assign v_pos = (COORD_W+1)'(vcnt);

  // One extra bit on the bounds keeps a sprite parked near the top of the coordinate range from wrapping.
  always_comb begin
    hit = '0;
    x0  = '0;
    y0  = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      x0 = {1'b0, sh_x[i*COORD_W +: COORD_W]};
      y0 = {1'b0, sh_y[i*COORD_W +: COORD_W]};
      hit[i] = sh_en[i]
               && (h_pos >= x0) && (h_pos < x0 + (COORD_W+1)'(SPRITE_W))
               && (v_pos >= y0) && (v_pos < y0 + (COORD_W+1)'(SPRITE_H));
    end
  end

  // Walk from the highest index down so the lowest-index hit is the last writer.
  always_comb begin
    pix_color = sh_bg;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (hit[NUM_SPRITES-1-i]) begin
        pix_color = sh_col[(NUM_SPRITES-1-i)*PIX_W +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_sync      <= 1'b1;
      v_sync      <= 1'b1;
      blank_n     <= 1'b0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= latch;
      if (pix_tick) begin
        h_sync  <= !((32'(hcnt) >= 32'(HS_START)) && (32'(hcnt) < 32'(HS_END)));
        v_sync  <= !((32'(vcnt) >= 32'(VS_START)) && (32'(vcnt) < 32'(VS_END)));
        blank_n <= active;
        if (active) begin
          {red_out, green_out, blue_out} <= pix_color;
        end else begin
          {red_out, green_out, blue_out} <= '0;
        end
      end
    end
  end

`ifdef SPRITE_COLLIDE_EN
  logic [NUM_SPRITES-1:0] multi_hit;
  logic [NUM_SPRITES-1:0] coll_acc;

  always_comb begin
    multi_hit = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      multi_hit[i] = hit[i] && ((hit & ~(NUM_SPRITES'(1) << i)) != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_acc <= '0;
      collide  <= '0;
    end else if (latch) begin
      collide  <= coll_acc;
      coll_acc <= '0;
    end else if (pix_tick && active) begin
      coll_acc <= coll_acc | multi_hit;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a shrunken raster, every clk compared against a position-arithmetic model.
module tb_vga_sprite_engine;

  localparam int NS = 3, CW = 16, COLW = 8, SW = 6, SH = 5, DIV = 2;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [NS*CW-1:0]      sprite_x, sprite_y;
  logic [NS*3*COLW-1:0]  sprite_color;
  logic [NS-1:0]         sprite_en;
  logic [3*COLW-1:0]     bg_color;
  logic                  clk_25MHz, h_sync, v_sync, sync_n, blank_n, frame_start;
  logic [COLW-1:0]       red_out, green_out, blue_out;
`ifdef SPRITE_COLLIDE_EN
  logic [NS-1:0]         collide;
`endif

  vga_sprite_engine #(
    .NUM_SPRITES(NS), .COORD_W(CW), .COLOR_W(COLW), .SPRITE_W(SW), .SPRITE_H(SH),
    .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color),
    .sprite_en(sprite_en), .bg_color(bg_color),
    .clk_25MHz(clk_25MHz), .h_sync(h_sync), .v_sync(v_sync), .sync_n(sync_n),
    .blank_n(blank_n), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
`ifdef SPRITE_COLLIDE_EN
    .collide(collide),
`endif
    .frame_start(frame_start)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  int          sx [NS];
  int          sy [NS];
  bit          sen[NS];
  logic [23:0] scol[NS];
  logic [23:0] sbg;
  logic        e_hs, e_vs, e_bn, e_fs;
  logic [23:0] e_rgb;
  logic [NS-1:0] acc, e_col;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] hits(input int h, input int v);
    logic [NS-1:0] r;
    r = '0;
    for (int i = 0; i < NS; i++)
      r[i] = sen[i] && h >= sx[i] && h < sx[i] + SW && v >= sy[i] && v < sy[i] + SH;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sx[i] = 0; sy[i] = 0; sen[i] = 1'b0; scol[i] = '0;
    end
    sbg = '0; e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_fs = 1'b0;
    e_rgb = '0; acc = '0; e_col = '0;
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input logic [23:0] col, input bit en);
    sprite_x[i*CW +: CW]         = CW'(x);
    sprite_y[i*CW +: CW]         = CW'(y);
    sprite_color[i*24 +: 24]     = col;
    sprite_en[i]                 = en;
  endtask

  // One clk: outputs after tick k describe linear position k-1 of the raster.
  task automatic step();
    int k, p, h, v;
    logic [NS-1:0] ht;
    logic c25;
    @(posedge clk);
    #1;
    cyc++;
    e_fs = 1'b0;
    if (cyc % DIV == 0) begin
      k = cyc / DIV;
      p = k - 1;
      h = p % HT;
      v = (p / HT) % VT;
      ht = hits(h, v);
      e_hs = !(h >= HA + HF && h < HA + HF + HS);
      e_vs = !(v >= VA + VF && v < VA + VF + VS);
      e_bn = (h < HA) && (v < VA);
      e_rgb = '0;
      if (e_bn) begin
        e_rgb = sbg;
        for (int i = NS - 1; i >= 0; i--) if (ht[i]) e_rgb = scol[i];
        if ($countones(ht) >= 2) acc = acc | ht;
      end
      if (h == 0 && v == VA) begin
        for (int i = 0; i < NS; i++) begin
          sx[i]   = int'(sprite_x[i*CW +: CW]);
          sy[i]   = int'(sprite_y[i*CW +: CW]);
          sen[i]  = sprite_en[i];
          scol[i] = sprite_color[i*24 +: 24];
        end
        sbg   = bg_color;
        e_fs  = 1'b1;
        e_col = acc;
        acc   = '0;
      end
    end
    c25 = ((cyc % DIV) < DIV / 2);
    chk("pixel", {34'd0, clk_25MHz, frame_start, h_sync, v_sync, blank_n, sync_n, red_out, green_out, blue_out},
                 {34'd0, c25, e_fs, e_hs, e_vs, e_bn, 1'b0, e_rgb});
`ifdef SPRITE_COLLIDE_EN
    chk("collide", 64'(collide), 64'(e_col));
`endif
  endtask

  task automatic run_ticks(input int n);
    repeat (n * DIV) step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hs"}, 64'(h_sync), 64'd1);
    chk({tag, "_vs"}, 64'(v_sync), 64'd1);
    chk({tag, "_bn"}, 64'(blank_n), 64'd0);
    chk({tag, "_rgb"}, 64'({red_out, green_out, blue_out}), 64'd0);
    chk({tag, "_fs"}, 64'(frame_start), 64'd0);
    chk({tag, "_pclk"}, 64'(clk_25MHz), 64'd1);
`ifdef SPRITE_COLLIDE_EN
    chk({tag, "_coll"}, 64'(collide), 64'd0);
`endif
  endtask

  task automatic random_config();
    for (int i = 0; i < NS; i++)
      set_sprite(i, int'($urandom_range(0, HA + 4)), int'($urandom_range(0, VA + 3)),
                 24'($urandom), 1'($urandom));
    bg_color = 24'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    sprite_x = '0; sprite_y = '0; sprite_color = '0; sprite_en = '0; bg_color = '0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk_reset_state("reset");

    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    step();
    chk("no_tick_after_1clk", 64'(blank_n), 64'd0);
    step();
    chk("tick_after_2clk", 64'(blank_n), 64'd1);
    run_ticks(VA * HT + 1 - 1);

    // Each iteration: half a frame, new inputs mid-frame, half a frame ending on the latch tick.
    for (int it = 0; it < 8; it++) begin
      run_ticks(FRAME / 2);
      case (it)
        0: begin
          set_sprite(0, 10, 5, 24'hFF0000, 1'b1);
          set_sprite(1, 30, 15, 24'h123456, 1'b0);
          set_sprite(2, 0, 0, 24'h654321, 1'b0);
          bg_color = 24'h000040;
        end
        1: begin
          set_sprite(0, 20, 10, 24'h00FF00, 1'b1);
          set_sprite(1, 22, 12, 24'h0000FF, 1'b1);
          set_sprite(2, 0, 0, 24'hABCDEF, 1'b0);
        end
        2: begin
          set_sprite(0, 32'hFFF8, 10, 24'hFFFFFF, 1'b1);
          set_sprite(1, 35, 20, 24'h808080, 1'b1);
          set_sprite(2, 36, 21, 24'h0F0F0F, 1'b1);
        end
        default: random_config();
      endcase
      run_ticks(FRAME / 2);
`ifdef SPRITE_COLLIDE_EN
      if (it == 2) chk("overlap_collide", 64'(collide), 64'h3);
`endif
      if (it >= 1) begin
        // Moving sprite 0 now must not affect the frame already latched.
        sprite_x[0 +: CW] = CW'($urandom_range(0, HA));
      end
    end

    run_ticks(FRAME / 2 + HT / 3);
    reset = 1'b0;
    #1;
    model_reset();
    chk_reset_state("midframe_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    run_ticks(FRAME + VA * HT + 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
